lane_ctrl: RTL and testbench
============================

Name: lane_ctrl

Overview:
- Upstream stage of the car-display block; produces its 2-bit lane_select.
- Raw left/right button inputs are synchronised, debounced and edge-detected into move requests.
- A pending request commits only at a frame boundary (iFrameDone), so the car never changes lane mid-draw.
- Outputs the current lane and a one-cycle move pulse.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a button level is accepted (10 ms at 50 MHz).
- RESET_LANE, 2'b01, lane loaded on reset (middle lane).

Ports:
- iClock  in  1  system clock
- iResetn  in  1  synchronous, active-low reset
- iLeft  in  1  raw left button, active-high (inverted at top level if board key is active-low), asynchronous
- iRight  in  1  raw right button, active-high, asynchronous
- iFrameDone  in  1  one-cycle pulse from the drawing side when a full background+car pass completes
- oLane  out  2  committed lane: 00 left, 01 middle, 10 right; 11 never driven
- oMoved  out  1  one-cycle pulse on the cycle oLane changes
- oPending  out  1  high while an uncommitted move request is held

Behaviour:
- Reset: all state is cleared on any posedge iClock with iResetn=0 (synchronous).
  - oLane=RESET_LANE, oMoved=0, oPending=0.
  - Synchronisers=0, debounced levels=0, debounce counters=0, FSM=IDLE.
  - Reset asserted mid-operation discards any pending request and any partial debounce count.
- Synchronisation: 2-flop synchroniser per button.
- Debounce, per button:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - If the synced level equals the debounced level, the counter is cleared.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level toggles on that edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the debounced level.
- Edge detect: a request is the rising edge of a debounced level (registered previous value). Releases generate nothing.
- Request resolution in a given cycle:
  - Left edge only -> dir=LEFT.
  - Right edge only -> dir=RIGHT.
  - Both edges in the same cycle -> ignored; any pending request is unchanged.
- FSM, two states:
  - IDLE: a request -> PENDING, pend_dir<=dir, oPending=1 next cycle.
  - PENDING:
    - A new request replaces pend_dir (latest wins).
    - iFrameDone=1 -> commit, return to IDLE, oPending=0 next cycle.
    - If iFrameDone and a new request arrive in the same cycle: the old pend_dir commits and the new request is latched; state stays PENDING.
  - iFrameDone in IDLE has no effect.
- Commit:
  - LEFT: oLane decrements. RIGHT: oLane increments.
  - Boundary (no wrap): LEFT at 00 or RIGHT at 10 is dropped. oLane is unchanged, oMoved stays 0, and the pending request is still consumed.
  - oLane and oMoved update on the clock edge that samples iFrameDone=1. oMoved is high for exactly one cycle.
- Latency:
  - Press stable from the cycle it is first sampled: debounced high after 2+DEBOUNCE_CYCLES edges, oPending high 1 cycle later.
  - Lane change occurs on the first iFrameDone after that.
- Outputs are registered; oLane is never 2'b11.

Optional Feature:
- Macro LANE_CTRL_WRAP_EN.
- Defined: LEFT at 00 -> 10 and RIGHT at 10 -> 00; oMoved pulses on wrap.
- Undefined: the saturating behaviour above (dropped request, no pulse).

Decomposition:
- Package lane_pkg holds:
  - lane encodings LANE_L=2'b00, LANE_M=2'b01, LANE_R=2'b10;
  - dir_t enum {DIR_LEFT, DIR_RIGHT};
  - state_t enum {S_IDLE, S_PENDING}.
- One sub-module, btn_debounce (synchroniser + debounce counter + edge detect), instantiated twice; parameter DEBOUNCE_CYCLES; outputs level and rise pulse.

Test Plan (DEBOUNCE_CYCLES=4 in simulation):
- Reset: hold iResetn=0 for 3 cycles with iLeft=1 -> oLane=01, oMoved=0, oPending=0; no request after release until 4 stable cycles.
- Right press held 10 cycles, iFrameDone pulse at cycle 20 -> oPending rises at cycle 7 after first sample; oLane=10 and oMoved=1 for 1 cycle after the frame pulse.
- 3-cycle glitch on iLeft -> no oPending, oLane unchanged across 2 iFrameDone pulses.
- Saturation: oLane=10, Right press + iFrameDone -> oLane stays 10, oMoved=0, oPending cleared. With LANE_CTRL_WRAP_EN: oLane=00, oMoved=1.
- Latest wins: Left then Right presses before any iFrameDone, from lane 01 -> after iFrameDone, oLane=10.
- Simultaneous: iFrameDone and a new Left edge in the same cycle while Right is pending at lane 00 -> oLane=01, oMoved=1, oPending stays 1. Next iFrameDone -> oLane=00.

Source files
------------

// File: rtl/lane_pkg.sv
// Shared types for the lane controller: lane encodings, move direction
// and controller state.
package lane_pkg;

    localparam logic [1:0] LANE_L = 2'b00;
    localparam logic [1:0] LANE_M = 2'b01;
    localparam logic [1:0] LANE_R = 2'b10;

    typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_t;

    typedef enum logic {S_IDLE, S_PENDING} state_t;

endpackage

// File: rtl/lane_ctrl_if.sv
// Button / frame / lane bundle between the board-facing side (master)
// and the lane controller (slave).
interface lane_ctrl_if;

    logic       iLeft;
    logic       iRight;
    logic       iFrameDone;
    logic [1:0] oLane;
    logic       oMoved;
    logic       oPending;

    modport master (output iLeft, iRight, iFrameDone,
                    input  oLane, oMoved, oPending);

    modport slave  (input  iLeft, iRight, iFrameDone,
                    output oLane, oMoved, oPending);

endinterface

// File: rtl/lane_ctrl_btn_debounce.sv
// One raw button: 2-flop synchroniser, stable-count debounce and
// rising-edge detect on the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic iClock,
    input  logic iResetn,
    input  logic iBtn,
    output logic oLevel,
    output logic oRise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          prev_q,  prev_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    // Level toggles only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        sync1_d = iBtn;
        sync2_d = sync1_q;
        prev_d  = level_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) level_d = ~level_q;
            else                   cnt_d   = cnt_q + CW'(1);
        end
    end

    // State registers, synchronously cleared.
    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

    assign oLevel = level_q;
    assign oRise  = level_q & ~prev_q;

endmodule

// File: rtl/lane_ctrl.sv
// Lane controller: debounced left/right presses become move requests that
// commit only on a frame boundary. Optional macro LANE_CTRL_WRAP_EN makes
// moves past the outer lanes wrap around instead of being dropped.
module lane_ctrl
    import lane_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter logic [1:0] RESET_LANE      = 2'b01
) (
    input  logic iClock,
    input  logic iResetn,
    lane_ctrl_if.slave bus
);

    logic left_level, left_rise;
    logic right_level, right_rise;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
        .iClock (iClock),
        .iResetn(iResetn),
        .iBtn   (bus.iLeft),
        .oLevel (left_level),
        .oRise  (left_rise)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
        .iClock (iClock),
        .iResetn(iResetn),
        .iBtn   (bus.iRight),
        .oLevel (right_level),
        .oRise  (right_rise)
    );

    // Levels are kept on the sub-module for debug; requests use edges only.
    logic unused_levels;
    assign unused_levels = left_level ^ right_level;

    state_t     state_q,    state_d;
    dir_t       pend_dir_q, pend_dir_d;
    logic [1:0] lane_q,     lane_d;
    logic       moved_q,    moved_d;
    logic       pending_q,  pending_d;

    logic req, commit;
    dir_t dir;

    // Exactly one edge makes a request; coincident edges cancel out.
    assign req    = left_rise ^ right_rise;
    assign dir    = left_rise ? DIR_LEFT : DIR_RIGHT;
    assign commit = (state_q == S_PENDING) && bus.iFrameDone;

    // Next state: commit the held move on a frame boundary, latest request wins.
    always_comb begin
        state_d    = state_q;
        pend_dir_d = pend_dir_q;
        lane_d     = lane_q;
        moved_d    = 1'b0;
        if (commit) begin
            state_d = S_IDLE;
            if (pend_dir_q == DIR_LEFT) begin
                if (lane_q != LANE_L) begin
                    lane_d  = lane_q - 2'b01;
                    moved_d = 1'b1;
                end
`ifdef LANE_CTRL_WRAP_EN
                else begin
                    lane_d  = LANE_R;
                    moved_d = 1'b1;
                end
`endif
            end else begin
                if (lane_q != LANE_R) begin
                    lane_d  = lane_q + 2'b01;
                    moved_d = 1'b1;
                end
`ifdef LANE_CTRL_WRAP_EN
                else begin
                    lane_d  = LANE_L;
                    moved_d = 1'b1;
                end
`endif
            end
        end
        if (req) begin
            state_d    = S_PENDING;
            pend_dir_d = dir;
        end
        pending_d = (state_d == S_PENDING);
    end

    // FSM and registered outputs.
    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            state_q    <= S_IDLE;
            pend_dir_q <= DIR_LEFT;
            lane_q     <= RESET_LANE;
            moved_q    <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_dir_q <= pend_dir_d;
            lane_q     <= lane_d;
            moved_q    <= moved_d;
            pending_q  <= pending_d;
        end
    end

    assign bus.oLane    = lane_q;
    assign bus.oMoved   = moved_q;
    assign bus.oPending = pending_q;

endmodule

// File: tb/tb_lane_ctrl.sv
// Directed bench for lane_ctrl with a 4-cycle debounce.
module tb_lane_ctrl;

    logic iClock = 1'b0;
    logic iResetn;
    int   total = 0;
    int   bad   = 0;

    lane_ctrl_if bus();

    lane_ctrl #(.DEBOUNCE_CYCLES(4), .RESET_LANE(2'b01)) dut (
        .iClock (iClock),
        .iResetn(iResetn),
        .bus    (bus)
    );

    always #5 iClock = ~iClock;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge iClock);
            #1;
        end
    endtask

    task automatic do_reset();
        iResetn = 1'b0;
        bus.iLeft = 1'b0; bus.iRight = 1'b0; bus.iFrameDone = 1'b0;
        tick(2);
        iResetn = 1'b1;
    endtask

    // Hold a button long enough to register, release it and let the release settle.
    task automatic press(input logic right);
        if (right) bus.iRight = 1'b1; else bus.iLeft = 1'b1;
        tick(7);
        bus.iRight = 1'b0; bus.iLeft = 1'b0;
        tick(8);
    endtask

    task automatic test_reset();
        iResetn = 1'b0;
        bus.iLeft = 1'b1; bus.iRight = 1'b0; bus.iFrameDone = 1'b0;
        tick(3);
        total++;
        if ({bus.oLane, bus.oMoved, bus.oPending} !== {2'b01, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state lane/moved/pend got %b want 0100", {bus.oLane, bus.oMoved, bus.oPending});
        end
        iResetn = 1'b1;
        tick(6);
        total++;
        if (bus.oPending !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_early_req pending got %b want 0", bus.oPending);
        end
        tick(1);
        total++;
        if (bus.oPending !== 1'b1) begin
            bad++;
            $display("FAIL reset_held_left_req pending got %b want 1", bus.oPending);
        end
        // Reset mid-operation drops the held request.
        bus.iLeft = 1'b0;
        iResetn = 1'b0;
        tick(1);
        iResetn = 1'b1;
        bus.iFrameDone = 1'b1;
        tick(1);
        bus.iFrameDone = 1'b0;
        total++;
        if ({bus.oLane, bus.oMoved, bus.oPending} !== {2'b01, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_discard lane/moved/pend got %b want 0100", {bus.oLane, bus.oMoved, bus.oPending});
        end
    endtask

    task automatic test_move_right();
        do_reset();
        bus.iRight = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            tick(1);
            if (c == 6) begin
                total++;
                if (bus.oPending !== 1'b0) begin
                    bad++;
                    $display("FAIL right_pend_c6 got %b want 0", bus.oPending);
                end
            end
            if (c == 7) begin
                total++;
                if ({bus.oLane, bus.oPending} !== {2'b01, 1'b1}) begin
                    bad++;
                    $display("FAIL right_pend_c7 lane/pend got %b want 011", {bus.oLane, bus.oPending});
                end
            end
            if (c == 10) bus.iRight = 1'b0;
        end
        bus.iFrameDone = 1'b1;
        tick(1);
        bus.iFrameDone = 1'b0;
        total++;
        if ({bus.oLane, bus.oMoved, bus.oPending} !== {2'b10, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL right_commit lane/moved/pend got %b want 1010", {bus.oLane, bus.oMoved, bus.oPending});
        end
        tick(1);
        total++;
        if ({bus.oLane, bus.oMoved} !== {2'b10, 1'b0}) begin
            bad++;
            $display("FAIL right_pulse_width lane/moved got %b want 100", {bus.oLane, bus.oMoved});
        end
    endtask

    task automatic test_glitch();
        bus.iLeft = 1'b1;
        tick(3);
        bus.iLeft = 1'b0;
        tick(10);
        total++;
        if (bus.oPending !== 1'b0) begin
            bad++;
            $display("FAIL glitch_pend got %b want 0", bus.oPending);
        end
        for (int k = 0; k < 2; k++) begin
            bus.iFrameDone = 1'b1;
            tick(1);
            bus.iFrameDone = 1'b0;
            total++;
            if ({bus.oLane, bus.oMoved} !== {2'b10, 1'b0}) begin
                bad++;
                $display("FAIL glitch_frame%0d lane/moved got %b want 100", k, {bus.oLane, bus.oMoved});
            end
        end
    endtask

    task automatic test_saturate();
        logic [2:0] exp;
`ifdef LANE_CTRL_WRAP_EN
        exp = {2'b00, 1'b1};
`else
        exp = {2'b10, 1'b0};
`endif
        press(1'b1);
        total++;
        if (bus.oPending !== 1'b1) begin
            bad++;
            $display("FAIL sat_pend got %b want 1", bus.oPending);
        end
        bus.iFrameDone = 1'b1;
        tick(1);
        bus.iFrameDone = 1'b0;
        total++;
        if ({bus.oLane, bus.oMoved, bus.oPending} !== {exp, 1'b0}) begin
            bad++;
            $display("FAIL sat_commit lane/moved/pend got %b want %b", {bus.oLane, bus.oMoved, bus.oPending}, {exp, 1'b0});
        end
    endtask

    task automatic test_latest_wins();
        do_reset();
        press(1'b0);
        press(1'b1);
        total++;
        if ({bus.oLane, bus.oPending} !== {2'b01, 1'b1}) begin
            bad++;
            $display("FAIL latest_hold lane/pend got %b want 011", {bus.oLane, bus.oPending});
        end
        bus.iFrameDone = 1'b1;
        tick(1);
        bus.iFrameDone = 1'b0;
        total++;
        if ({bus.oLane, bus.oMoved, bus.oPending} !== {2'b10, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL latest_commit lane/moved/pend got %b want 1010", {bus.oLane, bus.oMoved, bus.oPending});
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        press(1'b0);
        bus.iFrameDone = 1'b1;
        tick(1);
        bus.iFrameDone = 1'b0;
        tick(1);
        total++;
        if ({bus.oLane, bus.oPending} !== {2'b00, 1'b0}) begin
            bad++;
            $display("FAIL simul_setup lane/pend got %b want 000", {bus.oLane, bus.oPending});
        end
        press(1'b1);
        // Left rise lands on the same edge as the frame pulse.
        bus.iLeft = 1'b1;
        tick(6);
        bus.iFrameDone = 1'b1;
        tick(1);
        bus.iFrameDone = 1'b0;
        bus.iLeft = 1'b0;
        total++;
        if ({bus.oLane, bus.oMoved, bus.oPending} !== {2'b01, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL simul_commit lane/moved/pend got %b want 0111", {bus.oLane, bus.oMoved, bus.oPending});
        end
        tick(8);
        bus.iFrameDone = 1'b1;
        tick(1);
        bus.iFrameDone = 1'b0;
        total++;
        if ({bus.oLane, bus.oMoved, bus.oPending} !== {2'b00, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL simul_second lane/moved/pend got %b want 0010", {bus.oLane, bus.oMoved, bus.oPending});
        end
    endtask

    initial begin
        iResetn = 1'b0;
        bus.iLeft = 1'b0; bus.iRight = 1'b0; bus.iFrameDone = 1'b0;
        test_reset();
        test_move_right();
        test_glitch();
        test_saturate();
        test_latest_wins();
        test_simultaneous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
